// File: rtl/chest_hare_egg_pipeline_pkg.sv
// Shared constants, egg FSM states and helpers for the chest/hare/egg pipeline.
package chest_hare_egg_pipeline_pkg;

    localparam logic [31:0] PHI = 32'h9E37_79B9;

    localparam logic [31:0] IV0 = 32'h6A09_E667;
    localparam logic [31:0] IV1 = 32'hBB67_AE85;
    localparam logic [31:0] IV2 = 32'h3C6E_F372;
    localparam logic [31:0] IV3 = 32'hA54F_F53A;
    localparam logic [31:0] IV4 = 32'h510E_527F;
    localparam logic [31:0] IV5 = 32'h9B05_688C;
    localparam logic [31:0] IV6 = 32'h1F83_D9AB;
    localparam logic [31:0] IV7 = 32'h5BE0_CD19;

    typedef enum logic [1:0] {
        EGG_IDLE,
        EGG_LOAD,
        EGG_ROUND,
        EGG_FINISH
    } egg_state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {x, x} << n;
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] iv_word(input logic [2:0] i);
        logic [31:0] w;
        case (i)
            3'd0:    w = IV0;
            3'd1:    w = IV1;
            3'd2:    w = IV2;
            3'd3:    w = IV3;
            3'd4:    w = IV4;
            3'd5:    w = IV5;
            3'd6:    w = IV6;
            default: w = IV7;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/chest_hare_egg_pipeline_egg.sv
// Iterative 256-bit hash engine: captures one hare word per job and reports the digest.
//
// state      | meaning
// -----------+--------------------------------------------------
// EGG_IDLE   | waiting for the hare to be running
// EGG_LOAD   | capture header word, seed state with IV, clear r
// EGG_ROUND  | one compression round per cycle, ROUNDS cycles
// EGG_FINISH | digest valid, done pulse
module egg_hash_engine
    import chest_hare_egg_pipeline_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  hare_word,
    output logic         busy,
    output logic         done,
    output logic [255:0] gold_hash
);

    localparam logic [7:0] LAST_R = 8'(ROUNDS - 1);

    egg_state_e          state_q, state_d;
    logic [7:0][31:0]    s_q, s_d;
    logic [31:0]         hdr_q, hdr_d;
    logic [7:0]          r_q, r_d;
    logic [255:0]        gold_q, gold_d;
    logic [31:0]         w;
    logic [31:0]         t;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EGG_IDLE;
            s_q     <= '0;
            hdr_q   <= '0;
            r_q     <= '0;
            gold_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            hdr_q   <= hdr_d;
            r_q     <= r_d;
            gold_q  <= gold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        hdr_d   = hdr_q;
        r_d     = r_q;
        gold_d  = gold_q;
        w       = '0;
        t       = '0;
        case (state_q)
            EGG_IDLE: begin
                if (start) state_d = EGG_LOAD;
            end
            EGG_LOAD: begin
                hdr_d = hare_word;
                for (int i = 0; i < 8; i++) s_d[i] = iv_word(3'(i));
                r_d     = '0;
                state_d = EGG_ROUND;
            end
            EGG_ROUND: begin
                // Only header word 0 is non-zero, so w[r mod 16] is hdr at r mod 16 == 0.
                w   = (r_q[3:0] == 4'd0) ? hdr_q : 32'd0;
                t   = rotl(s_q[0], 5'd5) + (s_q[1] ^ s_q[2]) + s_q[7] + w + (PHI + {24'd0, r_q});
                s_d = {s_q[6:0], t};
                r_d = r_q + 8'd1;
                if (r_q == LAST_R) begin
                    state_d = EGG_FINISH;
                    for (int i = 0; i < 8; i++) gold_d[32*(7-i) +: 32] = s_d[i] + iv_word(3'(i));
                end
            end
            EGG_FINISH: begin
                state_d = EGG_IDLE;
            end
            default: state_d = EGG_IDLE;
        endcase
    end

    assign busy      = (state_q == EGG_LOAD) || (state_q == EGG_ROUND);
    assign done      = (state_q == EGG_FINISH);
    assign gold_hash = gold_q;

endmodule

// File: rtl/chest_hare_egg_pipeline.sv
// Top: configuration handshake (chest), evolving 32-bit transform (hare), hash engine (egg).
module chest_hare_egg_pipeline
    import chest_hare_egg_pipeline_pkg::*;
#(
    parameter int NUM_ALGOS = 1,
    parameter int CFG_LAT   = 4,
    parameter int ROUNDS    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [5:0]   algo_select,
    input  logic [31:0]  data_in,
    input  logic         trigger_rebirth,
    output logic         algorithm_ready,
    output logic         config_error,
    output logic [31:0]  data_out,
    output logic [255:0] gold_hash,
    output logic         done,
    output logic         busy
);

    localparam int         CW          = (CFG_LAT < 1) ? 1 : $clog2(CFG_LAT + 1);
    localparam logic [CW-1:0] CFG_LAT_W = CW'(CFG_LAT);
    localparam logic [6:0] NUM_ALGOS_W = 7'(NUM_ALGOS);

    logic          latched_q, latched_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          cfg_err_q, cfg_err_d;
    logic [31:0]   data_out_q, data_out_d;
    logic          hare_en_q, hare_en_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latched_q  <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            cfg_err_q  <= 1'b0;
            data_out_q <= '0;
            hare_en_q  <= 1'b0;
        end else begin
            latched_q  <= latched_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            cfg_err_q  <= cfg_err_d;
            data_out_q <= data_out_d;
            hare_en_q  <= hare_en_d;
        end
    end

    always_comb begin
        latched_d = 1'b1;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        if (!latched_q) begin
            valid_d = ({1'b0, algo_select} < NUM_ALGOS_W);
            cnt_d   = CFG_LAT_W;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        ready_d   = ready_q | (latched_q & valid_q & (cnt_q == '0));
        cfg_err_d = cfg_err_q | (latched_q & ~valid_q);

        data_out_d = '0;
        if (ready_q) begin
            if (trigger_rebirth) data_out_d = data_in ^ PHI;
            else                 data_out_d = (data_in ^ rotl(data_out_q, 5'd5)) + PHI;
        end
        // Egg starts only once the hare has completed at least one update.
        hare_en_d = ready_q;
    end

    egg_hash_engine #(.ROUNDS(ROUNDS)) u_egg (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (hare_en_q),
        .hare_word (data_out_q),
        .busy      (busy),
        .done      (done),
        .gold_hash (gold_hash)
    );

    assign algorithm_ready = ready_q;
    assign config_error    = cfg_err_q;
    assign data_out        = data_out_q;

endmodule

// File: tb/tb_chest_hare_egg_pipeline.sv
// Self-checking bench: table vectors for the hare plus a cycle-schedule reference model.
module tb_chest_hare_egg_pipeline;

    localparam logic [31:0] PHI = 32'h9E37_79B9;
    localparam logic [31:0] IVT [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                                        32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    localparam int PERIOD = 67;
    localparam int FIRST_LOAD = 7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   algo_select;
    logic [31:0]  data_in;
    logic         trigger_rebirth;
    logic         algorithm_ready;
    logic         config_error;
    logic [31:0]  data_out;
    logic [255:0] gold_hash;
    logic         done;
    logic         busy;

    always #5 clk = ~clk;

    chest_hare_egg_pipeline dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .algo_select     (algo_select),
        .data_in         (data_in),
        .trigger_rebirth (trigger_rebirth),
        .algorithm_ready (algorithm_ready),
        .config_error    (config_error),
        .data_out        (data_out),
        .gold_hash       (gold_hash),
        .done            (done),
        .busy            (busy)
    );

    int checks = 0;
    int errors = 0;

    int           m_cyc = -1;
    bit           m_valid = 1'b0;
    logic [31:0]  hist [0:2047];
    logic [255:0] m_gold = '0;
    bit           have_prev = 1'b0;
    logic [31:0]  prev_hdr = '0;
    logic [255:0] prev_gold = '0;

    typedef struct {
        logic        trig;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    function automatic logic [31:0] rl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] hare_ref(input logic [31:0] prev, input logic [31:0] din, input logic trig);
        return trig ? (din ^ PHI) : ((din ^ rl5(prev)) + PHI);
    endfunction

    function automatic logic [255:0] digest(input logic [31:0] x);
        logic [31:0]  s [8];
        logic [31:0]  t;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) s[i] = IVT[i];
        for (int r = 0; r < 64; r++) begin
            t = rl5(s[0]) + (s[1] ^ s[2]) + s[7] + ((r % 16 == 0) ? x : 32'd0) + PHI + 32'(r);
            for (int i = 7; i > 0; i--) s[i] = s[i-1];
            s[0] = t;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = s[i] + IVT[i];
        return res;
    endfunction

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, m_cyc, act, exp);
        end
    endtask

    // One clock: sample inputs applied before the edge, advance the model, compare all outputs.
    task automatic tick();
        logic [31:0] din_a;
        logic        trig_a, rst_a;
        logic [5:0]  algo_a;
        logic        e_ready, e_err, e_busy, e_done;
        logic [31:0] e_do;
        int          p;
        din_a  = data_in;
        trig_a = trigger_rebirth;
        rst_a  = rst_n;
        algo_a = algo_select;
        @(posedge clk);
        #1;
        e_do = '0; e_busy = 1'b0; e_done = 1'b0;
        if (!rst_a) begin
            m_cyc     = -1;
            m_gold    = '0;
            have_prev = 1'b0;
            e_ready   = 1'b0;
            e_err     = 1'b0;
        end else begin
            m_cyc++;
            if (m_cyc == 0) m_valid = (algo_a == 6'd0);
            e_ready = m_valid && (m_cyc >= 5);
            e_err   = !m_valid && (m_cyc >= 1);
            if (m_cyc > 0 && m_valid && (m_cyc - 1) >= 5) e_do = hare_ref(hist[m_cyc-1], din_a, trig_a);
            hist[m_cyc] = e_do;
            if (m_valid && m_cyc >= FIRST_LOAD) begin
                p      = (m_cyc - FIRST_LOAD) % PERIOD;
                e_busy = (p <= 64);
                e_done = (p == 65);
                if (e_done) m_gold = digest(hist[m_cyc - 65]);
            end
        end
        cmp("algorithm_ready", 256'(algorithm_ready), 256'(e_ready));
        cmp("config_error", 256'(config_error), 256'(e_err));
        cmp("data_out", 256'(data_out), 256'(e_do));
        cmp("busy", 256'(busy), 256'(e_busy));
        cmp("done", 256'(done), 256'(e_done));
        cmp("gold_hash", gold_hash, m_gold);
        if (e_done) begin
            if (have_prev && prev_hdr != hist[m_cyc - 65]) begin
                checks++;
                if (gold_hash === prev_gold) begin
                    errors++;
                    $display("FAIL digest_changed cyc=%0d got=%h exp=different_from_previous", m_cyc, gold_hash);
                end
            end
            have_prev = 1'b1;
            prev_hdr  = hist[m_cyc - 65];
            prev_gold = gold_hash;
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0000, 32'h9E37_79B9};
        tbl[1] = '{1'b0, 32'h0000_0000, 32'h6526_B0EC};
        tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'h61C8_8646};
        tbl[3] = '{1'b0, 32'h1234_5678, 32'h0};
        tbl[4] = '{1'b1, 32'hDEAD_BEEF, 32'h0};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0};
        tbl[6] = '{1'b0, $urandom, 32'h0};
        tbl[7] = '{1'b0, $urandom, 32'h0};
        for (int i = 3; i < 8; i++) tbl[i].exp = hare_ref(tbl[i-1].exp, tbl[i].din, tbl[i].trig);

        rst_n = 1'b0; algo_select = 6'd7; data_in = '0; trigger_rebirth = 1'b0;
        repeat (3) tick();

        // Invalid configuration: nothing should ever start.
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            data_in         = $urandom;
            trigger_rebirth = ($urandom_range(0, 3) == 0);
        end

        // Valid configuration, hare vectors from the table right after ready.
        rst_n = 1'b0; algo_select = 6'd0; data_in = '0; trigger_rebirth = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            data_in         = tbl[i].din;
            trigger_rebirth = tbl[i].trig;
            tick();
            cmp("hare_vector", 256'(data_out), 256'(tbl[i].exp));
        end

        // Random evolution across several back-to-back jobs; later algo_select changes are ignored.
        for (int i = 0; i < 280; i++) begin
            data_in         = $urandom;
            trigger_rebirth = ($urandom_range(0, 7) == 0);
            if (i == 50) algo_select = 6'd7;
            tick();
        end

        // Reset in the middle of a job, then the full sequence again with identical timing.
        rst_n = 1'b0; algo_select = 6'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_in         = $urandom;
            trigger_rebirth = ($urandom_range(0, 5) == 0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        cmp("reset_busy", 256'(busy), 256'(0));
        cmp("reset_gold", gold_hash, 256'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            data_in         = $urandom;
            trigger_rebirth = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
